uart_mmio: RTL and testbench
============================

Name: uart_mmio

Overview:
- CPU-side bus peripheral for the RV32I core; it is the initiator end of the uart send/busy and rx_data/rx_ready interface.
- Buffers CPU-written bytes in a TX FIFO and feeds them to the uart with a send/busy handshake.
- Captures received bytes into an RX FIFO on each rx_ready rising edge.
- Exposes DATA/STATUS registers on a simple single-cycle memory-mapped bus.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of two, >=2)
RX_DEPTH, 8, RX FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
addr  input  2  word select: 0=DATA, 1=STATUS, 2/3 reserved
we  input  1  write strobe, one clk per access
re  input  1  read strobe, one clk per access
wdata  input  32  write data
rdata  output  32  read data, registered
send  output  1  to uart send
tx_data  output  8  to uart tx_data
busy  input  1  from uart busy (baud-tick domain)
rx_data  input  8  from uart rx_data (stable while rx_ready high)
rx_ready  input  1  from uart rx_ready (baud-tick domain)
irq  output  1  high when rx_valid or tx_empty-after-activity (see below)

Behaviour:
- Reset (reset=0, async): rdata=0, send=0, tx_data=0, irq=0, both FIFOs empty, all sticky flags=0, synchronizer flops=0, TX FSM=IDLE.
- busy and rx_ready each pass through a 2-flop synchronizer (busy_s, rdy_s). rdy_rise = rdy_s & ~rdy_s_d.
- Bus write, DATA: push wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_drop is set (sticky).
- Bus write, STATUS: writing 1 to bit3 clears rx_overrun; writing 1 to bit5 clears tx_drop. If a set and a clear hit the same cycle, set wins.
- Bus read: rdata updates on the clk edge where re=1, so 1-cycle latency. It holds its value otherwise.
  - DATA: {24'b0, rx_fifo_head}, and pops the RX FIFO on the same edge. If the RX FIFO is empty, returns 0 with no pop.
  - STATUS: {26'b0, tx_drop, busy_s, rx_overrun, rx_valid, tx_empty, tx_full}, bits 5..0.
  - Reserved addresses: return 0.
- we and re in the same cycle: both are performed.
- TX FSM:
  - IDLE: when the TX FIFO is non-empty and busy_s=0, pop the FIFO, load tx_data, assert send, go to WAIT_BUSY.
  - WAIT_BUSY: hold send=1 until busy_s=1, then send=0 and go to WAIT_DONE.
  - WAIT_DONE: when busy_s=0, go to IDLE.
  - tx_data is held constant from load until the next load.
  - Bytes are sent in FIFO order, with at most one byte in flight.
- RX path: on rdy_rise, push rx_data into the RX FIFO. If the FIFO is full and no pop happens that cycle, the byte is dropped and rx_overrun is set. If full with a simultaneous pop, the push succeeds and count is unchanged.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- irq = rx_valid | (tx_empty & tx_fsm==IDLE & tx_sent_flag).
  - tx_sent_flag is set when WAIT_DONE exits.
  - It is cleared by any DATA write.
- Reset mid-transfer: send drops immediately (async), the in-flight byte is abandoned, and FIFO contents are lost.

Decomposition:
- Shared package holds:
  - Register offsets: ADDR_DATA=0, ADDR_STATUS=1.
  - STATUS bit indices: TX_FULL=0, TX_EMPTY=1, RX_VALID=2, RX_OVR=3, BUSY=4, TX_DROP=5.
  - TX FSM state encodings: IDLE, WAIT_BUSY, WAIT_DONE.
- One natural sub-module: sync_fifo (WIDTH, DEPTH; push, pop, din, dout first-word-fall-through, full, empty, count), instantiated for both TX and RX.
- Synchronizers stay inline.

Test Plan:
- Reset: drive reset=0 mid-activity -> send=0, rdata=0, STATUS read = 0x02 (tx_empty only), irq=0.
- TX order: write DATA 0x41, 0x42, 0x43. Bench uart model raises busy 3 clk after send and holds it 20 clk -> three send pulses, tx_data sequence 41,42,43, send never reasserted while busy_s=1, irq=1 after the last byte.
- TX full: with busy held high, write 9 bytes (TX_DEPTH=8) -> STATUS tx_full=1 and tx_drop=1, and only the first 8 bytes are transmitted. Write STATUS 0x20 -> tx_drop=0.
- RX capture: pulse rx_ready with rx_data=0x5A, then 0xC3 -> STATUS rx_valid=1. DATA reads return 0x5A then 0xC3 one cycle after re. A third read returns 0 and rx_valid=0.
- RX overrun: 9 rx_ready pulses with no reads -> rx_overrun=1, FIFO holds the first 8 bytes in order. Clear-write coinciding with a new overrun -> flag stays 1.
- Simultaneous: RX FIFO full, DATA read on the same cycle as rdy_rise -> no overrun, count stays 8, popped byte is correct.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the uart_mmio peripheral: register map, STATUS bit layout, TX FSM states.
package uart_mmio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_VALID = 2;
    localparam int unsigned ST_RX_OVR   = 3;
    localparam int unsigned ST_BUSY     = 4;
    localparam int unsigned ST_TX_DROP  = 5;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, send/busy handshake to the uart, DATA/STATUS registers.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        send,
    output logic [7:0]  tx_data,
    input  logic        busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        irq
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic            r_busy_m, r_busy_s;
    logic            r_rdy_m, r_rdy_s, r_rdy_d;
    logic            r_tx_drop, r_rx_ovr, r_sent;
    tx_state_e       r_state;

    logic            w_rdy_rise, w_wr_data, w_wr_stat, w_rd_data, w_done_exit;
    logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic            w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]      w_tx_dout, w_rx_dout;
    logic [TX_CW-1:0] w_tx_count;
    logic [RX_CW-1:0] w_rx_count;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_rdy_rise  = r_rdy_s & ~r_rdy_d;
    assign w_wr_data   = we & (addr == ADDR_DATA);
    assign w_wr_stat   = we & (addr == ADDR_STATUS);
    assign w_rd_data   = re & (addr == ADDR_DATA);
    assign w_tx_push   = w_wr_data & ~w_tx_full;
    assign w_tx_pop    = (r_state == TX_IDLE) & ~w_tx_empty & ~r_busy_s;
    assign w_rx_pop    = w_rd_data & ~w_rx_empty;
    assign w_done_exit = (r_state == TX_WAIT_DONE) & ~r_busy_s;
    assign w_unused    = ^{w_tx_count, w_rx_count, wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(w_tx_push), .pop(w_tx_pop), .din(wdata[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(w_rdy_rise), .pop(w_rx_pop), .din(rx_data),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_VALID] = ~w_rx_empty;
        w_status[ST_RX_OVR]   = r_rx_ovr;
        w_status[ST_BUSY]     = r_busy_s;
        w_status[ST_TX_DROP]  = r_tx_drop;
    end

    // Synchronizers, sticky flags, read port and interrupt; a flag set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_m  <= 1'b0;
            r_busy_s  <= 1'b0;
            r_rdy_m   <= 1'b0;
            r_rdy_s   <= 1'b0;
            r_rdy_d   <= 1'b0;
            r_tx_drop <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_sent    <= 1'b0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            r_busy_m  <= busy;
            r_busy_s  <= r_busy_m;
            r_rdy_m   <= rx_ready;
            r_rdy_s   <= r_rdy_m;
            r_rdy_d   <= r_rdy_s;
            r_tx_drop <= (w_wr_data & w_tx_full)
                       | (r_tx_drop & ~(w_wr_stat & wdata[ST_TX_DROP]));
            r_rx_ovr  <= (w_rdy_rise & w_rx_full & ~w_rx_pop)
                       | (r_rx_ovr & ~(w_wr_stat & wdata[ST_RX_OVR]));
            r_sent    <= w_done_exit | (r_sent & ~w_wr_data);
            irq       <= ~w_rx_empty | (w_tx_empty & (r_state == TX_IDLE) & r_sent);
            if (re) begin
                case (addr)
                    ADDR_DATA:   rdata <= w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
                    ADDR_STATUS: rdata <= w_status;
                    default:     rdata <= 32'h0;
                endcase
            end
        end
    end

    // TX handshake: offer one byte, wait for the uart to take it, then wait for it to finish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= TX_IDLE;
            send    <= 1'b0;
            tx_data <= 8'h0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        tx_data <= w_tx_dout;
                        send    <= 1'b1;
                        r_state <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (r_busy_s) begin
                        send    <= 1'b0;
                        r_state <= TX_WAIT_DONE;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!r_busy_s) r_state <= TX_IDLE;
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_mmio;

    localparam int unsigned TX_DEPTH = 8;
    localparam int unsigned RX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        send;
    logic [7:0]  tx_data;
    logic        busy = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ready = 1'b0;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;
    bit busy_force = 1'b0;
    logic [7:0] tx_log[$];

    uart_mmio #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .send(send), .tx_data(tx_data), .busy(busy),
        .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte queues and flags; expected outputs as they stand after each edge.
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    bit          m_tx_drop = 0, m_rx_ovr = 0, m_sent = 0;
    bit          m_b1 = 0, m_bs = 0, m_r1 = 0, m_rs = 0, m_rd = 0;
    int          m_phase = 0;
    logic        m_send = 1'b0, m_irq = 1'b0;
    logic [7:0]  m_txd = 8'h0;
    logic [31:0] m_rdata = 32'h0;

    always @(posedge clk or negedge reset) begin : model
        bit wr_d, wr_s, rd_d, rise, txfull, rxfull, rxpop, ovr_set, drop_set, sent_set;
        if (!reset) begin
            m_txq.delete(); m_rxq.delete();
            m_tx_drop = 0; m_rx_ovr = 0; m_sent = 0;
            m_b1 = 0; m_bs = 0; m_r1 = 0; m_rs = 0; m_rd = 0;
            m_phase = 0; m_send = 0; m_irq = 0; m_txd = 8'h0; m_rdata = 32'h0;
        end else begin
            wr_d   = we && addr == 2'd0;
            wr_s   = we && addr == 2'd1;
            rd_d   = re && addr == 2'd0;
            rise   = m_rs && !m_rd;
            txfull = m_txq.size() == TX_DEPTH;
            rxfull = m_rxq.size() == RX_DEPTH;
            rxpop  = rd_d && m_rxq.size() != 0;
            m_irq  = (m_rxq.size() != 0) || (m_txq.size() == 0 && m_phase == 0 && m_sent);
            if (re) begin
                if (addr == 2'd0)
                    m_rdata = (m_rxq.size() != 0) ? {24'h0, m_rxq[0]} : 32'h0;
                else if (addr == 2'd1)
                    m_rdata = {26'h0, m_tx_drop, m_bs, m_rx_ovr, m_rxq.size() != 0,
                               m_txq.size() == 0, txfull};
                else
                    m_rdata = 32'h0;
            end
            sent_set = 0;
            if (m_phase == 0 && m_txq.size() != 0 && !m_bs) begin
                m_txd = m_txq.pop_front(); m_send = 1; m_phase = 1;
            end else if (m_phase == 1 && m_bs) begin
                m_send = 0; m_phase = 2;
            end else if (m_phase == 2 && !m_bs) begin
                m_phase = 0; sent_set = 1;
            end
            if (rxpop) void'(m_rxq.pop_front());
            ovr_set = rise && rxfull && !rxpop;
            if (rise && !ovr_set) m_rxq.push_back(rx_data);
            drop_set = wr_d && txfull;
            if (wr_d && !txfull) m_txq.push_back(wdata[7:0]);
            m_rx_ovr  = ovr_set  || (m_rx_ovr  && !(wr_s && wdata[3]));
            m_tx_drop = drop_set || (m_tx_drop && !(wr_s && wdata[5]));
            m_sent    = sent_set || (m_sent && !wr_d);
            m_rd = m_rs; m_rs = m_r1; m_r1 = rx_ready;
            m_bs = m_b1; m_b1 = busy;
        end
    end

    // Every-cycle comparison against the model, plus a log of bytes offered to the uart.
    always @(negedge clk) begin : compare
        static logic prev_send = 1'b0;
        if (reset) begin
            chk("send", 32'(send), 32'(m_send));
            chk("tx_data", 32'(tx_data), 32'(m_txd));
            chk("rdata", rdata, m_rdata);
            chk("irq", 32'(irq), 32'(m_irq));
            if (send && !prev_send) begin
                tx_log.push_back(tx_data);
                chk("send_while_busy", 32'(m_bs), 32'h0);
            end
            prev_send = send;
        end else begin
            prev_send = 1'b0;
        end
    end

    // Uart model: busy rises 3 clk after send and stays high 20 clk, unless forced high.
    initial begin : uart
        forever begin
            @(posedge clk); #1;
            if (busy_force) busy = 1'b1;
            else if (send && !busy) begin
                repeat (3) @(posedge clk);
                #1 busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 busy = 1'b0;
            end else busy = 1'b0;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        @(posedge clk); #1;
        re = 1'b0;
        d = rdata;
    endtask

    // rx_ready pulse; act 1 = STATUS clear-overrun write, act 2 = DATA read, aligned to the rising-edge capture.
    task automatic rx_pulse(input logic [7:0] b, input int act, output logic [31:0] d);
        rx_data = b; rx_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        if (act == 1) begin we = 1'b1; addr = 2'd1; wdata = 32'h08; end
        if (act == 2) begin re = 1'b1; addr = 2'd0; end
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        d = rdata;
        repeat (2) begin @(posedge clk); #1; end
        rx_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d;
        bit ok;
        int n;
        logic [7:0] exp_b;

        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_send", 32'(send), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        bus_read(2'd1, d);
        chk("reset_status", d, 32'h02);

        // TX order
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        bus_write(2'd0, 32'h43);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (tx_log.size() == 3) begin ok = 1; break; end
        end
        chk("tx3_wait", 32'(ok), 32'h1);
        repeat (40) @(posedge clk); #1;
        chk("tx3_count", tx_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk("tx3_byte", 32'(tx_log[i]), 32'h41 + i);
        chk("tx3_irq", 32'(irq), 32'h1);

        // TX full / drop
        busy_force = 1'b1;
        tx_log.delete();
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h10 + i);
        bus_read(2'd1, d);
        chk("txfull_status", d, 32'h31);
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d);
        chk("txdrop_clr_status", d, 32'h11);
        busy_force = 1'b0;
        ok = 0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1;
            if (tx_log.size() >= 8) begin ok = 1; break; end
        end
        chk("tx8_wait", 32'(ok), 32'h1);
        repeat (60) @(posedge clk); #1;
        chk("tx8_count", tx_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk("tx8_byte", 32'(tx_log[i]), 32'h10 + i);
        chk("tx8_irq", 32'(irq), 32'h1);

        // RX capture
        rx_pulse(8'h5A, 0, d);
        rx_pulse(8'hC3, 0, d);
        bus_read(2'd1, d);
        chk("rx2_status", d, 32'h06);
        bus_read(2'd0, d);
        chk("rx_read0", d, 32'h5A);
        bus_read(2'd0, d);
        chk("rx_read1", d, 32'hC3);
        bus_read(2'd0, d);
        chk("rx_read_empty", d, 32'h0);
        bus_read(2'd1, d);
        chk("rx_drained_status", d, 32'h02);
        bus_read(2'd3, d);
        chk("reserved_read", d, 32'h0);

        // RX overrun
        for (int i = 0; i < 9; i++) rx_pulse(8'h60 + 8'(i), 0, d);
        bus_read(2'd1, d);
        chk("rxovr_status", d, 32'h0E);
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, d);
        chk("rxovr_clr_status", d, 32'h06);
        rx_pulse(8'h69, 1, d);
        bus_read(2'd1, d);
        chk("rxovr_set_wins", d, 32'h0E);
        bus_write(2'd1, 32'h08);

        // Full RX FIFO with a pop on the capture edge
        rx_pulse(8'h6A, 2, d);
        chk("simul_pop_byte", d, 32'h60);
        bus_read(2'd1, d);
        chk("simul_status", d, 32'h06);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, d);
            exp_b = (i < 7) ? 8'h61 + 8'(i) : 8'h6A;
            chk("simul_drain", d, {24'h0, exp_b});
        end
        bus_read(2'd0, d);
        chk("simul_empty", d, 32'h0);

        // Reset mid-transfer
        bus_read(2'd1, d);
        chk("pre_reset_status", d, 32'h02);
        bus_write(2'd0, 32'h70);
        bus_write(2'd0, 32'h71);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (send) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("midreset_send_seen", 32'(ok), 32'h1);
        n = tx_log.size();
        reset = 1'b0;
        #1;
        chk("midreset_send", 32'(send), 32'h0);
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        repeat (5) @(posedge clk); #1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("midreset_busy_wait", 32'(ok), 32'h1);
        reset = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus_read(2'd1, d);
        chk("postreset_status", d, 32'h02);
        repeat (40) begin @(posedge clk); #1; end
        chk("postreset_no_send", tx_log.size(), 32'(n));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
